// File: rtl/median_filter_3x3_if.sv
// median_filter_3x3_if: grey pixel stream into and out of the 3x3 median filter
interface median_filter_3x3_if #(parameter int DW = 8);
  logic          per_frame_vsync;
  logic          per_frame_href;
  logic          per_frame_clken;
  logic [DW-1:0] per_img_gray;
  logic          post_frame_vsync;
  logic          post_frame_href;
  logic          post_frame_clken;
  logic [DW-1:0] post_img_gray;
  modport master (
    output per_frame_vsync, per_frame_href, per_frame_clken, per_img_gray,
    input  post_frame_vsync, post_frame_href, post_frame_clken, post_img_gray
  );
  modport slave (
    input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_gray,
    output post_frame_vsync, post_frame_href, post_frame_clken, post_img_gray
  );
endinterface

// File: rtl/median_filter_3x3.sv
// median_filter_3x3: line-buffered 3x3 window feeding a pipelined median network, fixed 7-cycle latency
module median_filter_3x3 #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DW         = 8
) (
  input logic clk,
  input logic reset,
  median_filter_3x3_if.slave pix_if
);
  localparam int CW  = $clog2(IMG_WIDTH);
  localparam int RW  = $clog2(IMG_HEIGHT);
  localparam int LAT = 7;
  logic                    vs_q, hr_q, armed_q;
  logic [CW-1:0]           col_q, col_d;
  logic [RW-1:0]           row_q, row_d;
  logic [DW-1:0]           lb1_q [IMG_WIDTH];
  logic [DW-1:0]           lb2_q [IMG_WIDTH];
  logic [2:0][2:0][DW-1:0] win_q;
  logic [2:0][DW-1:0]      tap;
  logic [2:0][DW-1:0]      hi_q, md_q, lo_q, med_q;
  logic [DW-1:0]           a_q, b_q, c_q, gray_q;
  logic [LAT-1:0]          ck_q, vsd_q, hrd_q;
  logic [LAT-2:0]          bd_q;
  logic                    vs_rise, hr_fall, en, ck;
  function automatic logic [DW-1:0] mx(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return a > b ? a : b;
  endfunction
  function automatic logic [DW-1:0] mn(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return a < b ? a : b;
  endfunction
  function automatic logic [DW-1:0] md3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                        input logic [DW-1:0] c);
    return mx(mn(a, b), mn(mx(a, b), c));
  endfunction
  // vs_q resets high so a frame already in progress at reset release is ignored
  assign vs_rise = pix_if.per_frame_vsync & ~vs_q;
  assign hr_fall = ~pix_if.per_frame_href & hr_q;
  assign en      = armed_q | vs_rise;
  assign ck      = pix_if.per_frame_clken & en;
  assign tap     = {pix_if.per_img_gray, lb1_q[col_q], lb2_q[col_q]};
  always_comb begin
    col_d = (vs_rise || hr_fall) ? '0 :
            ck ? (col_q == CW'(IMG_WIDTH - 1) ? '0 : col_q + 1'b1) : col_q;
    row_d = vs_rise ? '0 :
            (hr_fall && row_q != RW'(IMG_HEIGHT - 1)) ? row_q + 1'b1 : row_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_q    <= 1'b1;
      hr_q    <= 1'b0;
      armed_q <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      ck_q    <= '0;
      vsd_q   <= '0;
      hrd_q   <= '0;
      bd_q    <= '0;
      gray_q  <= '0;
      win_q   <= '0;
    end else begin
      vs_q    <= pix_if.per_frame_vsync;
      hr_q    <= pix_if.per_frame_href;
      armed_q <= en;
      col_q   <= col_d;
      row_q   <= row_d;
      ck_q    <= {ck_q[LAT-2:0], ck};
      vsd_q   <= {vsd_q[LAT-2:0], pix_if.per_frame_vsync & en};
      hrd_q   <= {hrd_q[LAT-2:0], pix_if.per_frame_href & en};
      bd_q    <= {bd_q[LAT-3:0], row_q < RW'(2) || col_q < CW'(2)};
      gray_q  <= (ck_q[LAT-2] && !bd_q[LAT-2]) ? med_q[2] : '0;
      if (ck)
        for (int i = 0; i < 3; i++) win_q[i] <= {tap[i], win_q[i][2:1]};
    end
  end
  always_ff @(posedge clk) begin
    if (ck) begin
      lb1_q[col_q] <= pix_if.per_img_gray;
      lb2_q[col_q] <= lb1_q[col_q];
    end
  end
  // Data stages run every cycle; validity rides on the ck_q/bd_q delay lines
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      hi_q[i] <= mx(mx(win_q[i][0], win_q[i][1]), win_q[i][2]);
      md_q[i] <= md3(win_q[i][0], win_q[i][1], win_q[i][2]);
      lo_q[i] <= mn(mn(win_q[i][0], win_q[i][1]), win_q[i][2]);
    end
    a_q   <= mn(mn(hi_q[0], hi_q[1]), hi_q[2]);
    b_q   <= md3(md_q[0], md_q[1], md_q[2]);
    c_q   <= mx(mx(lo_q[0], lo_q[1]), lo_q[2]);
    med_q <= {med_q[1:0], md3(a_q, b_q, c_q)};
  end
  assign pix_if.post_frame_vsync = vsd_q[LAT-1];
  assign pix_if.post_frame_href  = hrd_q[LAT-1];
  assign pix_if.post_frame_clken = ck_q[LAT-1];
  assign pix_if.post_img_gray    = gray_q;
endmodule

// File: tb/tb_median_filter_3x3.sv
// tb_median_filter_3x3: table-driven 3x3 windows on 8x4 frames plus gap, reset and back-to-back sequences
module tb_median_filter_3x3;
  localparam int W = 8, H = 4, DW = 8;
  typedef struct packed {
    logic [0:8][7:0] win;
    logic [7:0]      bg;
    logic [7:0]      exp;
  } rec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  median_filter_3x3_if #(.DW(DW)) bus ();
  median_filter_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DW(DW)) dut (
    .clk(clk), .reset(rst), .pix_if(bus)
  );
  rec_t       recs [6];
  logic [7:0] img [H][W];
  logic [7:0] outq [$];
  logic [7:0] expq [$];
  logic [2:0] h [7] = '{default: '0};
  int         nchk = 0, nerr = 0;
  bit         lat_en = 1'b1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual %0h, required %0h", nm, act, exp);
    end
  endtask
  // post_* must equal the driven vsync/href/clken seven cycles earlier; gray is 0 off-strobe
  always @(negedge clk) begin
    if (lat_en)
      chk("delay7/gray0",
          {bus.post_frame_vsync, bus.post_frame_href, bus.post_frame_clken,
           bus.post_frame_clken || bus.post_img_gray == 8'h00},
          {h[6], 1'b1});
    if (bus.post_frame_clken) outq.push_back(bus.post_img_gray);
    for (int i = 6; i > 0; i--) h[i] <= h[i-1];
    h[0] <= {bus.per_frame_vsync, bus.per_frame_href, bus.per_frame_clken};
  end
  task automatic cyc(input logic v, input logic hr, input logic ck, input logic [7:0] px,
                     input int n = 1);
    repeat (n) begin
      @(posedge clk); #1;
      bus.per_frame_vsync = v;
      bus.per_frame_href  = hr;
      bus.per_frame_clken = ck;
      bus.per_img_gray    = px;
    end
  endtask
  task automatic send_frame(input bit gap, input int tail);
    cyc(1, 0, 0, 0, 3);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        cyc(1, 1, 1, img[r][c]);
        if (gap) cyc(1, 1, 0, 0);
      end
      cyc(1, 0, 0, 0, 3);
    end
    cyc(0, 0, 0, 0, tail);
  endtask
  function automatic logic [7:0] med9(input int r, input int c);
    logic [7:0] v [9];
    logic [7:0] t;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++) v[dr*3+dc] = img[r-2+dr][c-2+dc];
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
    return v[4];
  endfunction
  task automatic build_exp();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) expq.push_back((r < 2 || c < 2) ? 8'h00 : med9(r, c));
  endtask
  task automatic cmp(input string nm);
    chk({nm, " pulses"}, outq.size(), expq.size());
    for (int i = 0; i < expq.size(); i++)
      if (i < outq.size()) chk($sformatf("%s r%0d c%0d", nm, i / W, i % W), outq[i], expq[i]);
    outq.delete();
    expq.delete();
  endtask
  task automatic rand_img();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 8'($urandom);
  endtask
  task automatic rec_img(input int k);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = (r < 3 && c < 3) ? recs[k].win[r*3+c] : recs[k].bg;
  endtask
  initial begin
    bus.per_frame_vsync = 1'b0;
    bus.per_frame_href  = 1'b0;
    bus.per_frame_clken = 1'b0;
    bus.per_img_gray    = '0;
    recs[0] = {{9{8'h55}}, 8'h55, 8'h55};
    recs[1] = {{8'h10, 8'h10, 8'h10, 8'h10, 8'hFF, 8'h10, 8'h10, 8'h10, 8'h10}, 8'h10, 8'h10};
    recs[2] = {{8'd9, 8'd1, 8'd5, 8'd3, 8'd7, 8'd2, 8'd8, 8'd4, 8'd6}, 8'h00, 8'd5};
    recs[3] = {{9{8'hFF}}, 8'hFF, 8'hFF};
    recs[4] = {{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h80}, 8'h00, 8'h80};
    recs[5] = {{8'd200, 8'd10, 8'd200, 8'd10, 8'd200, 8'd10, 8'd200, 8'd10, 8'd100}, 8'd50, 8'd100};
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", {bus.post_frame_vsync, bus.post_frame_href, bus.post_frame_clken,
                          bus.post_img_gray}, 32'h0);
    rst = 1'b0;
    cyc(0, 0, 0, 0, 3);
    for (int k = 0; k < 6; k++) begin
      rec_img(k);
      build_exp();
      send_frame(0, 12);
      chk($sformatf("rec%0d centre", k), outq.size() > 2*W+2 ? 32'(outq[2*W+2]) : 32'hdead,
          recs[k].exp);
      cmp($sformatf("rec%0d", k));
    end
    rec_img(2);
    build_exp();
    send_frame(1, 12);
    cmp("clken gaps");
    rand_img();
    cyc(1, 0, 0, 0, 3);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == 2 && c == 4) begin
          chk("vsync before reset", bus.post_frame_vsync, 1);
          lat_en = 1'b0;
          #1 rst = 1'b1;
          #1 chk("async reset clears", {bus.post_frame_vsync, bus.post_frame_href,
                                        bus.post_frame_clken, bus.post_img_gray}, 32'h0);
          outq.delete();
          repeat (3) @(posedge clk);
          #1 rst = 1'b0;
        end
        cyc(1, 1, 1, img[r][c]);
      end
      cyc(1, 0, 0, 0, 3);
    end
    cyc(0, 0, 0, 0, 12);
    chk("silent until vsync", outq.size(), 0);
    outq.delete();
    lat_en = 1'b1;
    rand_img();
    build_exp();
    send_frame(0, 12);
    cmp("after reset");
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 8'hFF;
    build_exp();
    send_frame(0, 2);
    rand_img();
    build_exp();
    send_frame(0, 12);
    cmp("back-to-back");
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end
endmodule
